// File: rtl/pkt_desc_bram_fifo.sv
// Packet descriptor FIFO: one BRAM with registered read,
// a prefetch register and an output register for full-rate streaming.
`ifndef PKT_DESC_NBITS
`define PKT_DESC_NBITS 52
`endif

package pkt_desc_pkg;
    typedef struct packed {
        logic [3:0]  src_port;
        logic [3:0]  dst_port;
        logic [13:0] len;
        logic [9:0]  idx;
    } sch_pkt_desc_type;

    typedef struct packed {
        logic [3:0]       q_id;
        logic [7:0]       conn_id;
        logic [3:0]       conn_group_id;
        logic [3:0]       port_queue_id;
        sch_pkt_desc_type sch_pkt_desc;
    } pkt_desc_type;
endpackage

module pkt_desc_bram_fifo
    import pkt_desc_pkg::*;
#(
    parameter int DEPTH_NBITS  = 4,
    parameter int AFULL_THRESH = (1 << DEPTH_NBITS) - 4,
    parameter int WIDTH        = `PKT_DESC_NBITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 wr,
    input  pkt_desc_type         din,
    output logic                 full,
    output logic                 afull,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output pkt_desc_type         dout,
    output logic                 empty,
    output logic [DEPTH_NBITS:0] count,
    output logic                 overflow
);
    localparam int DEPTH = 1 << DEPTH_NBITS;
    localparam int CW    = DEPTH_NBITS + 1;

    typedef logic [DEPTH_NBITS-1:0] ptr_t;
    typedef logic [CW-1:0]          cnt_t;

    localparam cnt_t DEPTH_C = cnt_t'(DEPTH);
    localparam cnt_t AFULL_C = cnt_t'(AFULL_THRESH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] rdata_q;
    logic [WIDTH-1:0] bdata_q, bdata_d;

    ptr_t wr_ptr_q, wr_ptr_d;
    ptr_t rd_ptr_q, rd_ptr_d;
    cnt_t cnt_q, cnt_d;
    cnt_t ram_cnt_q, ram_cnt_d;
    logic a_vld_q, a_vld_d;
    logic b_vld_q, b_vld_d;
    logic ovf_q, ovf_d;

    logic push, pop, b_free, a_mv, bypass, rd_en;

    assign wdata = {din.q_id, din.conn_id, din.conn_group_id,
                    din.port_queue_id,
                    din.sch_pkt_desc.src_port,
                    din.sch_pkt_desc.dst_port,
                    din.sch_pkt_desc.len,
                    din.sch_pkt_desc.idx};

    assign {dout.q_id, dout.conn_id, dout.conn_group_id,
            dout.port_queue_id,
            dout.sch_pkt_desc.src_port,
            dout.sch_pkt_desc.dst_port,
            dout.sch_pkt_desc.len,
            dout.sch_pkt_desc.idx} = bdata_q;

    // Stage A = BRAM read register, stage B = output register.
    // A push that meets a pop with nothing queued ahead of it is
    // steered straight into B so a one-deep stream has no bubbles;
    // it is still written to RAM and both pointers advance.
    assign full   = (cnt_q == DEPTH_C);
    assign afull  = (cnt_q >= AFULL_C);
    assign empty  = (cnt_q == '0);
    assign count  = cnt_q;
    assign overflow   = ovf_q;
    assign dout_valid = b_vld_q;

    assign push   = wr && !full && !rst;
    assign pop    = b_vld_q && dout_ready;
    assign b_free = !b_vld_q || pop;
    assign a_mv   = a_vld_q && b_free;
    assign bypass = push && pop && !a_vld_q && (ram_cnt_q == '0);
    assign rd_en  = (ram_cnt_q != '0) && (!a_vld_q || a_mv);

    // Next-state for pointers, occupancy and pipeline stages
    always_comb begin
        wr_ptr_d  = wr_ptr_q + ptr_t'(push);
        rd_ptr_d  = rd_ptr_q + ptr_t'(rd_en || bypass);
        cnt_d     = cnt_q + cnt_t'(push) - cnt_t'(pop);
        ram_cnt_d = ram_cnt_q + cnt_t'(push)
                  - cnt_t'(rd_en) - cnt_t'(bypass);
        a_vld_d   = rd_en || (a_vld_q && !a_mv);
        b_vld_d   = a_mv || bypass || (b_vld_q && !pop);
        ovf_d     = ovf_q || (wr && full);
        bdata_d   = bdata_q;
        if (a_mv) begin
            bdata_d = rdata_q;
        end else if (bypass) begin
            bdata_d = wdata;
        end
    end

    // BRAM: one write port, one registered read port, never reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= wdata;
        end
        if (rd_en) begin
            rdata_q <= mem[rd_ptr_q];
        end
    end

    // Output data register holds while stalled
    always_ff @(posedge clk) begin
        bdata_q <= bdata_d;
    end

    // Control state with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            ram_cnt_q <= '0;
            a_vld_q   <= 1'b0;
            b_vld_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            ram_cnt_q <= ram_cnt_d;
            a_vld_q   <= a_vld_d;
            b_vld_q   <= b_vld_d;
            ovf_q     <= ovf_d;
        end
    end
endmodule

// File: tb/tb_pkt_desc_bram_fifo.sv
// Bench for pkt_desc_bram_fifo: queue reference model with a
// negedge monitor plus directed latency/fill/stream/reset cases.
module tb_pkt_desc_bram_fifo;
    import pkt_desc_pkg::*;

    localparam int DN    = 4;
    localparam int DEPTH = 16;
    localparam int AF    = 12;

    logic         clk = 1'b0;
    logic         rst, wr, dout_ready;
    logic         full, afull, dout_valid, empty, overflow;
    pkt_desc_type din, dout;
    logic [DN:0]  count;

    always #5 clk = ~clk;

    pkt_desc_bram_fifo #(
        .DEPTH_NBITS (DN),
        .AFULL_THRESH(AF)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr        (wr),
        .din       (din),
        .full      (full),
        .afull     (afull),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout      (dout),
        .empty     (empty),
        .count     (count),
        .overflow  (overflow)
    );

    pkt_desc_type exp_q[$];
    int           nvec = 0;
    int           nerr = 0;
    int           pre_sz = 0;
    bit           ovf_m = 1'b0;
    bit           mon_en = 1'b0;
    bit           stall_prev = 1'b0;
    pkt_desc_type prev_dout;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    function automatic pkt_desc_type rnd();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return pkt_desc_type'(r[$bits(pkt_desc_type)-1:0]);
    endfunction

    // Monitor: flags against the model, pops and compares on accept
    always @(negedge clk) begin
        if (mon_en) begin
            pre_sz = exp_q.size();
            chk("count", 64'(count), 64'(pre_sz));
            chk("empty", 64'(empty), 64'(pre_sz == 0));
            chk("full", 64'(full), 64'(pre_sz == DEPTH));
            chk("afull", 64'(afull), 64'(pre_sz >= AF));
            chk("overflow", 64'(overflow), 64'(ovf_m));
            if (pre_sz == 0)
                chk("valid_when_empty", 64'(dout_valid), 64'd0);
            if (stall_prev) begin
                chk("stall_valid", 64'(dout_valid), 64'd1);
                chk("stall_data", 64'(dout), 64'(prev_dout));
            end
            if (dout_valid === 1'b1 && dout_ready === 1'b1) begin
                if (pre_sz == 0) begin
                    nvec++;
                    nerr++;
                    $display("FAIL pop_unexpected: got 0x%0h, expected none",
                             dout);
                end else begin
                    chk("dout", 64'(dout), 64'(exp_q.pop_front()));
                end
            end
            stall_prev = !rst && (dout_valid === 1'b1) && !dout_ready;
            prev_dout  = dout;
        end
    end

    // Apply one cycle of stimulus; model the push side at the edge
    task automatic step(input logic w, input pkt_desc_type d,
                        input logic r);
        wr         = w;
        din        = d;
        dout_ready = r;
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            ovf_m = 1'b0;
        end else if (w) begin
            if (pre_sz < DEPTH) exp_q.push_back(d);
            else ovf_m = 1'b1;
        end
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step(1'b1, rnd(), 1'b0);
        rst = 1'b0;
        chk("rst_valid", 64'(dout_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_empty", 64'(empty), 64'd1);
    endtask

    task automatic wait_valid(input string nm, input int budget);
        int n;
        n = 0;
        while (dout_valid !== 1'b1 && n < budget) begin
            step(1'b0, '0, 1'b0);
            n++;
        end
        chk({nm, "_wait_valid"}, 64'(dout_valid), 64'd1);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || dout_valid === 1'b1) && n < budget) begin
            step(1'b0, '0, 1'b1);
            n++;
        end
        chk("drain_empty", 64'(empty), 64'd1);
    endtask

    initial begin
        pkt_desc_type d;
        rst        = 1'b1;
        wr         = 1'b0;
        din        = '0;
        dout_ready = 1'b0;

        // Reset, with wr held high to show it is ignored
        step(1'b1, rnd(), 1'b1);
        step(1'b1, rnd(), 1'b1);
        rst    = 1'b0;
        mon_en = 1'b1;
        chk("init_count", 64'(count), 64'd0);
        chk("init_empty", 64'(empty), 64'd1);
        chk("init_full", 64'(full), 64'd0);
        chk("init_afull", 64'(afull), 64'd0);
        chk("init_valid", 64'(dout_valid), 64'd0);
        chk("init_overflow", 64'(overflow), 64'd0);

        // Single push: visible after E+2, not before
        d = '0;
        d.sch_pkt_desc.idx = 10'h5;
        step(1'b1, d, 1'b1);
        chk("lat_after_e", 64'(dout_valid), 64'd0);
        step(1'b0, '0, 1'b1);
        chk("lat_after_e1", 64'(dout_valid), 64'd0);
        step(1'b0, '0, 1'b1);
        chk("lat_after_e2", 64'(dout_valid), 64'd1);
        chk("single_idx", 64'(dout.sch_pkt_desc.idx), 64'h5);
        step(1'b0, '0, 1'b1);
        chk("single_empty", 64'(empty), 64'd1);
        chk("single_count", 64'(count), 64'd0);

        // Fill to capacity, overflow attempt, ordered drain
        for (int i = 1; i <= DEPTH; i++) begin
            d = rnd();
            d.sch_pkt_desc.idx = 10'(i);
            step(1'b1, d, 1'b0);
            chk("fill_afull", 64'(afull), 64'(i >= AF));
        end
        chk("fill_full", 64'(full), 64'd1);
        chk("fill_count", 64'(count), 64'd16);
        step(1'b1, rnd(), 1'b0);
        chk("ovf_set", 64'(overflow), 64'd1);
        chk("ovf_count", 64'(count), 64'd16);
        for (int i = 1; i <= DEPTH; i++) begin
            wait_valid("fill_drain", 8);
            chk("drain_idx", 64'(dout.sch_pkt_desc.idx), 64'(i));
            step(1'b0, '0, 1'b1);
        end
        chk("fill_drained", 64'(empty), 64'd1);
        pulse_reset();

        // Full with simultaneous push and pop
        for (int i = 0; i < DEPTH; i++) step(1'b1, rnd(), 1'b0);
        wait_valid("full_pp", 8);
        step(1'b1, rnd(), 1'b1);
        chk("full_pp_ovf", 64'(overflow), 64'd1);
        chk("full_pp_count", 64'(count), 64'd15);
        pulse_reset();

        // Reset mid-stream discards held entries
        for (int i = 0; i < 8; i++) step(1'b1, rnd(), 1'b0);
        wait_valid("mid_rst", 8);
        chk("mid_rst_held", 64'(count), 64'd8);
        pulse_reset();
        d = rnd();
        step(1'b1, d, 1'b0);
        wait_valid("post_rst", 8);
        chk("post_rst_data", 64'(dout), 64'(d));
        step(1'b0, '0, 1'b1);
        chk("post_rst_empty", 64'(empty), 64'd1);

        // Streaming one-deep push+pop every cycle
        step(1'b1, rnd(), 1'b0);
        wait_valid("stream", 8);
        for (int i = 0; i < 100; i++) begin
            step(1'b1, rnd(), 1'b1);
            chk("stream_valid", 64'(dout_valid), 64'd1);
            chk("stream_count", 64'(count), 64'd1);
        end
        drain(20);

        // Random push and backpressure
        for (int i = 0; i < 800; i++) begin
            step(1'($urandom_range(0, 99) < 60), rnd(),
                 1'($urandom_range(0, 1)));
        end
        drain(60);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/pkt_desc_bram_fifo.md
PKT_DESC_BRAM_FIFO -- requirements
Module: pkt_desc_bram_fifo

Interface
REQ-001 Parameter DEPTH_NBITS, default 4, log2 of descriptor capacity; DEPTH = 1<<DEPTH_NBITS.
REQ-002 Parameter AFULL_THRESH, default DEPTH-4, occupancy at or above which afull asserts.
REQ-003 Parameter WIDTH, default `PKT_DESC_NBITS, packed descriptor width.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst  input  1  synchronous, active-high reset.
REQ-006 Port wr  input  1  push request; din is sampled on the same edge.
REQ-007 Port din  input  pkt_desc_type  descriptor to enqueue.
REQ-008 Port full  output  1  occupancy == DEPTH.
REQ-009 Port afull  output  1  occupancy >= AFULL_THRESH.
REQ-010 Port dout_valid  output  1  dout holds the oldest descriptor.
REQ-011 Port dout_ready  input  1  consumer accepts dout; a pop occurs when dout_valid && dout_ready.
REQ-012 Port dout  output  pkt_desc_type  head descriptor.
REQ-013 Port empty  output  1  occupancy == 0.
REQ-014 Port count  output  DEPTH_NBITS+1  occupancy, 0..DEPTH.
REQ-015 Port overflow  output  1  sticky flag: a push was attempted while full.

Function
REQ-016 Storage SHALL be one block RAM of DEPTH x WIDTH with registered read, one write port and one read port; contents are not reset.
REQ-017 Packing into RAM SHALL be, MSB to LSB: q_id, conn_id, conn_group_id, port_queue_id, sch_pkt_desc.src_port, sch_pkt_desc.dst_port, sch_pkt_desc.len, sch_pkt_desc.idx; dout unpacks the same order.
REQ-018 Occupancy SHALL count every accepted, not-yet-popped descriptor, including any held in read pipeline or output registers; total capacity is exactly DEPTH.
REQ-019 A push SHALL be accepted iff wr && !full at the edge; full is evaluated on pre-edge occupancy, so a push while full is rejected even with a simultaneous pop.
REQ-020 A rejected push SHALL leave contents, pointers and count unchanged and set overflow to 1 until rst.
REQ-021 On an accepted push alone, count SHALL increment by 1; on a pop alone, it SHALL decrement by 1; on both together, it SHALL remain unchanged.
REQ-022 Write and read pointers SHALL be DEPTH_NBITS wide and wrap from DEPTH-1 to 0.
REQ-023 Order SHALL be strict FIFO; every accepted descriptor SHALL appear on dout exactly once, bit-exact.
REQ-024 Latency: for a push accepted at edge E into an empty FIFO, dout_valid SHALL be 1 after edge E+2 and not before.
REQ-025 With dout_ready held 1 and data available, the FIFO SHALL sustain one pop per cycle with no bubbles; a prefetch/skid stage behind the BRAM read register makes this possible.
REQ-026 While dout_valid && !dout_ready, dout and dout_valid SHALL hold stable.
REQ-027 dout_valid SHALL never assert while occupancy is 0; dout_ready while !dout_valid has no effect.
REQ-028 The RAM read address SHALL never equal an entry written on the same edge that has not yet committed; no read-during-write hazard is relied upon.
REQ-029 full, afull, empty and count SHALL be registered or decoded from registered occupancy only, with no combinational path from wr or dout_ready.

Reset
REQ-030 While rst=1 at an edge: pointers 0, count 0, empty 1, full 0, afull 0, dout_valid 0, overflow 0; dout value is don't-care.
REQ-031 rst asserted mid-operation SHALL discard all stored and in-flight descriptors; no pre-reset descriptor SHALL appear on dout afterwards.
REQ-032 wr asserted in the same cycle as rst SHALL be ignored.

Verification
REQ-033 Single push: push idx=0x5 at edge E with dout_ready=1 -> dout_valid=1 after E+2 with idx=0x5; popped next edge; empty=1, count=0.
REQ-034 Fill: DEPTH=16, 16 pushes with dout_ready=0 -> full=1, count=16, afull from count=12; a 17th push -> overflow=1, count stays 16; draining yields descriptors 1..16 in order.
REQ-035 Streaming: push and pop every cycle for 100 cycles after priming with 1 entry -> count constant at 1, no gaps in dout_valid, data in order, pointers wrap at least 6 times.
REQ-036 Backpressure: dout_ready toggled randomly while pushing random descriptors -> dout stable while stalled, output matches a reference queue bit-exact for all fields.
REQ-037 Full with simultaneous push and pop: count=16, wr=1 and pop on the same edge -> push rejected, overflow=1, count=15.
REQ-038 Reset mid-stream: 8 entries held, rst pulsed one cycle -> dout_valid=0, count=0, overflow=0 next cycle; the next push returns only the new descriptor.
